// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter. Data has fixed priority; a starvation
// counter forces an instruction grant after STARVE_LIMIT data grants in a row.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  output logic                    i_ack_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_strb_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_ack_o,
  output logic                    m_req_o,
  output logic                    m_we_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_strb_o,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic                    m_ack_i,
  output logic                    busy_o,
  output logic                    owner_o
);

  // state  | meaning
  // S_IDLE | arbitrate, latch winner into M_* registers
  // S_BUSY | memory request outstanding, wait for M_ACK
  // S_DONE | one-cycle ACK pulse to the owner
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_WIDTH-1:0] m_strb_q, m_strb_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  busy_q, busy_d;
  logic                  owner_q, owner_d;
  logic [7:0]            starve_q, starve_d;
  logic                  grant_inst, grant_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_strb_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_strb_q  <= m_strb_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
    end
  end

  // Data wins unless the instruction side has waited out the starvation limit.
  assign grant_data = d_req_i && !(i_req_i && (starve_q == LIMIT));
  assign grant_inst = i_req_i && !grant_data;

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_strb_d  = m_strb_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    owner_d   = owner_q;
    starve_d  = starve_q;

    case (state_q)
      S_IDLE: begin
        if (grant_inst) begin
          state_d  = S_BUSY;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_strb_d = '0;
          m_addr_d = i_addr_i;
          owner_d  = 1'b0;
          starve_d = '0;
        end else if (grant_data) begin
          state_d   = S_BUSY;
          m_req_d   = 1'b1;
          m_we_d    = d_we_i;
          m_addr_d  = d_addr_i;
          m_wdata_d = d_wdata_i;
          m_strb_d  = d_strb_i;
          owner_d   = 1'b1;
          if (!i_req_i)
            starve_d = '0;
          else if (starve_q < LIMIT)
            starve_d = starve_q + 8'd1;
        end else begin
          starve_d = '0;
        end
      end
      S_BUSY: begin
        if (m_ack_i) begin
          state_d = S_DONE;
          m_req_d = 1'b0;
          if (owner_q) begin
            d_ack_d = 1'b1;
            if (!m_we_q) d_rdata_d = m_rdata_i;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata_i;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign m_strb_o  = m_strb_q;
  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign i_ack_o   = i_ack_q;
  assign d_ack_o   = d_ack_q;
  assign busy_o    = busy_q;
  assign owner_o   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after each rising edge,
// outputs are checked at that same point, well away from the next edge.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_rdata_o;
  logic        i_ack_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_strb_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_strb_o;
  logic [31:0] m_rdata_i;
  logic        m_ack_i;
  logic        busy_o;
  logic        owner_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_strb_i(d_strb_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_strb_o(m_strb_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_req"},   m_req_o,   0);
    chk({tag, "_m_we"},    m_we_o,    0);
    chk({tag, "_m_addr"},  m_addr_o,  0);
    chk({tag, "_m_wdata"}, m_wdata_o, 0);
    chk({tag, "_m_strb"},  m_strb_o,  0);
    chk({tag, "_i_rdata"}, i_rdata_o, 0);
    chk({tag, "_d_rdata"}, d_rdata_o, 0);
    chk({tag, "_i_ack"},   i_ack_o,   0);
    chk({tag, "_d_ack"},   d_ack_o,   0);
    chk({tag, "_busy"},    busy_o,    0);
    chk({tag, "_owner"},   owner_o,   0);
  endtask

  initial begin
    logic [9:0] exp_order;
    int         last_req_cyc;

    rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; d_strb_i = '0; m_rdata_i = '0; m_ack_i = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    tick();

    // Single instruction read, zero-wait memory.
    i_req_i = 1'b1; i_addr_i = 32'h0000_0004;
    tick();
    chk("inst_m_req", m_req_o, 1);
    chk("inst_m_addr", m_addr_o, 32'h4);
    chk("inst_m_we", m_we_o, 0);
    chk("inst_m_strb", m_strb_o, 0);
    chk("inst_owner", owner_o, 0);
    chk("inst_busy", busy_o, 1);
    chk("inst_ack_early", i_ack_o, 0);
    m_ack_i = 1'b1; m_rdata_i = 32'h7D00_8113;
    tick();
    chk("inst_ack", i_ack_o, 1);
    chk("inst_rdata", i_rdata_o, 32'h7D00_8113);
    chk("inst_d_ack", d_ack_o, 0);
    chk("inst_m_req_drop", m_req_o, 0);
    m_ack_i = 1'b0; i_req_i = 1'b0;
    tick();
    chk("inst_ack_pulse", i_ack_o, 0);
    chk("inst_idle", busy_o, 0);

    // Data write, memory waits 3 cycles.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_strb_i = 4'b0011;
    tick();
    for (int w = 0; w < 3; w++) begin
      chk("wr_m_req", m_req_o, 1);
      chk("wr_m_we", m_we_o, 1);
      chk("wr_m_addr", m_addr_o, 32'h100);
      chk("wr_m_wdata", m_wdata_o, 32'hDEAD_BEEF);
      chk("wr_m_strb", m_strb_o, 4'b0011);
      chk("wr_owner", owner_o, 1);
      chk("wr_ack_early", d_ack_o, 0);
      tick();
    end
    m_ack_i = 1'b1; m_rdata_i = 32'h1234_5678;
    tick();
    chk("wr_d_ack", d_ack_o, 1);
    chk("wr_d_rdata_kept", d_rdata_o, 0);
    chk("wr_i_ack", i_ack_o, 0);
    m_ack_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; d_strb_i = '0;
    tick();
    chk("wr_ack_pulse", d_ack_o, 0);

    // Spurious M_ACK while idle.
    m_ack_i = 1'b1; m_rdata_i = 32'hFFFF_FFFF;
    tick();
    m_ack_i = 1'b0;
    chk("stale_busy", busy_o, 0);
    chk("stale_m_req", m_req_o, 0);
    chk("stale_i_ack", i_ack_o, 0);
    chk("stale_d_ack", d_ack_o, 0);
    chk("stale_i_rdata", i_rdata_o, 32'h7D00_8113);
    chk("stale_d_rdata", d_rdata_o, 0);
    tick();
    chk("stale_still_idle", busy_o, 0);

    // Contention with both requests held: D,D,D,D,I,D,D,D,D,I.
    exp_order = 10'b01111_01111;  // bit g = expected owner of grant g
    i_req_i = 1'b1; i_addr_i = 32'h80; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
    for (int g = 0; g < 10; g++) begin
      tick();
      chk("cont_owner", owner_o, exp_order[g]);
      chk("cont_m_addr", m_addr_o, exp_order[g] ? 32'h300 : 32'h80);
      m_ack_i = 1'b1; m_rdata_i = 32'hA000_0000 + 32'(g);
      tick();
      m_ack_i = 1'b0;
      chk("cont_d_ack", d_ack_o, exp_order[g]);
      chk("cont_i_ack", i_ack_o, !exp_order[g]);
      if (exp_order[g]) chk("cont_d_rdata", d_rdata_o, 32'hA000_0000 + 32'(g));
      else              chk("cont_i_rdata", i_rdata_o, 32'hA000_0000 + 32'(g));
      if (g == 9) begin i_req_i = 1'b0; d_req_i = 1'b0; end
      tick();
    end
    chk("cont_idle", busy_o, 0);

    // Back-to-back fetches 0x0, 0x4, 0x8.
    last_req_cyc = 0;
    i_req_i = 1'b1; i_addr_i = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_m_req", m_req_o, 1);
      chk("b2b_m_addr", m_addr_o, 32'(4 * k));
      if (k > 0) chk("b2b_spacing", cyc - last_req_cyc, 3);
      last_req_cyc = cyc;
      m_ack_i = 1'b1; m_rdata_i = 32'hB000_0000 + 32'(k);
      tick();
      m_ack_i = 1'b0;
      chk("b2b_i_ack", i_ack_o, 1);
      chk("b2b_i_rdata", i_rdata_o, 32'hB000_0000 + 32'(k));
      tick();
      chk("b2b_no_dup_req", m_req_o, 0);
      chk("b2b_no_dup_ack", i_ack_o, 0);
      i_addr_i = 32'(4 * (k + 1));
      if (k == 2) i_req_i = 1'b0;
    end
    tick();
    chk("b2b_idle", busy_o, 0);

    // Reset during BUSY, then a late M_ACK.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200;
    tick();
    chk("rst_busy_m_req", m_req_o, 1);
    rst_i = 1'b1;
    tick();
    chk_reset_outputs("rst_mid");
    rst_i = 1'b0; d_req_i = 1'b0;
    tick();
    m_ack_i = 1'b1; m_rdata_i = 32'hCAFE_F00D;
    tick();
    m_ack_i = 1'b0;
    chk("rst_late_busy", busy_o, 0);
    chk("rst_late_d_ack", d_ack_o, 0);
    chk("rst_late_i_ack", i_ack_o, 0);
    chk("rst_late_d_rdata", d_rdata_o, 0);
    i_req_i = 1'b1; i_addr_i = 32'h40;
    tick();
    chk("rst_new_m_req", m_req_o, 1);
    chk("rst_new_m_addr", m_addr_o, 32'h40);
    m_ack_i = 1'b1; m_rdata_i = 32'h0000_55AA;
    tick();
    m_ack_i = 1'b0; i_req_i = 1'b0;
    chk("rst_new_i_ack", i_ack_o, 1);
    chk("rst_new_i_rdata", i_rdata_o, 32'h0000_55AA);
    tick();
    chk("rst_new_done", i_ack_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter that shares a single memory port between the core's instruction-fetch stage and its data (load/store) stage. It sits between the core's fetch and memory-access units and the external memory bridge. Arbitration is fixed-priority (data first), with a starvation guard that forces an instruction grant after a bounded run of data grants. Exactly one transaction is outstanding at any time.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive data grants allowed while I_REQ is pending (legal range 1..255)

Ports:
- CLK  in  1  clock; one clock domain for the whole block
- RST  in  1  reset, synchronous, active-high
- I_REQ  in  1  instruction read request; held until I_ACK
- I_ADDR  in  ADDR_WIDTH  fetch address; stable while I_REQ=1
- I_RDATA  out  DATA_WIDTH  fetched word; valid when I_ACK=1
- I_ACK  out  1  one-cycle completion pulse
- D_REQ  in  1  data request; held until D_ACK
- D_WE  in  1  1=write, 0=read
- D_ADDR  in  ADDR_WIDTH  data address
- D_WDATA  in  DATA_WIDTH  write data
- D_STRB  in  DATA_WIDTH/8  byte enables (writes only)
- D_RDATA  out  DATA_WIDTH  read data; valid when D_ACK=1
- D_ACK  out  1  one-cycle completion pulse
- M_REQ  out  1  memory request; held until M_ACK
- M_WE, M_ADDR, M_WDATA, M_STRB  out  1/ADDR/DATA/STRB  registered copy of the granted request
- M_RDATA  in  DATA_WIDTH  memory read data; valid with M_ACK
- M_ACK  in  1  one-cycle memory completion pulse
- BUSY  out  1  1 whenever the FSM is not IDLE
- OWNER  out  1  owner of the current or last transaction: 0=inst, 1=data

## Operation
- FSM states:
  - IDLE: arbitrate.
    - If any request is present: latch the winner's signals into the M_* registers, set OWNER, go to BUSY.
    - If no request is present: stay in IDLE.
  - BUSY: M_REQ=1. On M_ACK, latch M_RDATA into the owner's RDATA register and go to DONE.
  - DONE: pulse the owner's ACK for exactly one cycle, then return to IDLE. M_REQ=0.
- Arbitration in IDLE:
  - Only one request present: that requester wins.
  - Both requests present: data wins, except when starve_cnt == STARVE_LIMIT, in which case inst wins.
- starve_cnt (8-bit):
  - Increments on a data grant made while I_REQ=1.
  - Clears on any inst grant.
  - Clears in IDLE when I_REQ=0.
  - Saturates at STARVE_LIMIT.
- Inst grants drive M_WE=0 and M_STRB=0. M_WDATA keeps its previous value (don't-care).
- On a write, the owner's RDATA register is not updated. The ACK still pulses.
- Requests seen in BUSY or DONE are ignored. The requester keeps REQ high and is re-arbitrated in the next IDLE.
- Requesters must present their next request, or drop REQ, in the cycle after ACK. DONE→IDLE guarantees that a stale REQ is never double-granted.

## Timing
- Reset values: I_ACK=0, D_ACK=0, M_REQ=0, M_WE=0, M_ADDR=0, M_WDATA=0, M_STRB=0, I_RDATA=0, D_RDATA=0, BUSY=0, OWNER=0, starve_cnt=0, state=IDLE.
- Cycle timeline, with REQ sampled in IDLE at cycle T:
  - T+1: M_REQ=1.
  - First M_ACK at cycle T+1+k, where k≥0.
  - T+2+k: xACK=1 and RDATA valid.
- Minimum latency is 2 cycles REQ→ACK. Minimum spacing between memory requests is 3 cycles.
- M_ACK arriving while in IDLE or DONE is ignored (stale or spurious).
- All outputs are registered. No combinational path from any input to any output.
- RST asserted in any state: on the next edge, all outputs and state take their reset values. An in-flight transaction is abandoned with no ACK. A late M_ACK after reset is ignored in IDLE.
- Simultaneous I_REQ and D_REQ rising in the same IDLE cycle: arbitration as above. The loser stays pending with no lost state.

## Test plan
- Single inst read:
  - Stimulus: I_REQ, I_ADDR=0x0000_0004; memory returns M_RDATA=0x7D00_8113 with zero-wait M_ACK.
  - Required: M_REQ at T+1; I_ACK at T+2 with I_RDATA=0x7D00_8113; D_ACK stays 0.
- Data write:
  - Stimulus: D_WE=1, D_ADDR=0x100, D_WDATA=0xDEAD_BEEF, D_STRB=4'b0011; memory waits 3 cycles.
  - Required: M_* equal the request throughout BUSY; D_ACK at T+5; D_RDATA unchanged.
- Contention with STARVE_LIMIT=4:
  - Stimulus: I_REQ and D_REQ held continuously.
  - Required grant order: D,D,D,D,I,D,D,D,D,I; never 5 consecutive D grants while I_REQ is pending.
- Back-to-back:
  - Stimulus: fetch requests 0x0, 0x4, 0x8 issued immediately after each ACK.
  - Required: M_REQ rises every 3 cycles; each I_ACK carries the matching word; no duplicate grant.
- Reset mid-transaction:
  - Stimulus: RST during BUSY, then M_ACK 2 cycles later.
  - Required: all outputs reset on the next edge; no I_ACK or D_ACK; the late M_ACK is ignored; a new request is served normally afterward.
- Stale M_ACK:
  - Stimulus: M_ACK pulse while in IDLE with no request present.
  - Required: state stays IDLE; no ACK; RDATA unchanged.
